// File: rtl/mem_responder.sv
// mem_responder: word memory serving single processor accesses plus a loader write port.
// Define MEM_WAIT_EN to insert WAIT_CYCLES wait states before each processor access.
module mem_responder #(
   parameter int WORD_W      = 10,
   parameter int ADDR_W      = 7,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              CS,
   input  logic              R_NW,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   output logic              ld_ready
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      LOAD = 2'd3
   } state_t;

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be within 1..15");
   end

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WORD_W-1:0] mem_r [DEPTH];
   logic [WORD_W-1:0] rdata_r;
   logic              ready_r;
   logic              ld_ready_r;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [WORD_W-1:0] mem_wdata_s;
   logic              rd_en_s;
   logic [ADDR_W-1:0] rd_addr_s;
`ifdef MEM_WAIT_EN
   logic [3:0]        cnt_r;
   logic [3:0]        cnt_nxt_s;
   logic              capture_s;
   logic              rnw_r;
   logic [ADDR_W-1:0] addr_r;
   logic [WORD_W-1:0] wdata_r;
`endif

   // Next-state, memory write strobe and read strobe selection
   always_comb begin
      state_nxt_s = state_r;
      mem_we_s    = 1'b0;
      mem_waddr_s = ld_addr;
      mem_wdata_s = ld_data;
      rd_en_s     = 1'b0;
      rd_addr_s   = addr;
`ifdef MEM_WAIT_EN
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (CS) begin
`ifdef MEM_WAIT_EN
               capture_s   = 1'b1;
               cnt_nxt_s   = 4'(WAIT_CYCLES - 1);
               state_nxt_s = WAIT;
`else
               rd_en_s     = R_NW;
               mem_we_s    = ~R_NW;
               mem_waddr_s = addr;
               mem_wdata_s = wdata;
               state_nxt_s = RESP;
`endif
            end else if (ld_valid) begin
               mem_we_s    = 1'b1;
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
`ifdef MEM_WAIT_EN
         WAIT: begin
            // Dropping CS abandons the access before anything is touched
            if (!CS) begin
               cnt_nxt_s   = 4'd0;
               state_nxt_s = IDLE;
            end else if (cnt_r == 4'd0) begin
               rd_en_s     = rnw_r;
               rd_addr_s   = addr_r;
               mem_we_s    = ~rnw_r;
               mem_waddr_s = addr_r;
               mem_wdata_s = wdata_r;
               state_nxt_s = RESP;
            end else begin
               cnt_nxt_s   = cnt_r - 4'd1;
            end
         end
`endif
         RESP:    state_nxt_s = IDLE;
         LOAD:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_r    <= IDLE;
         rdata_r    <= '0;
         ready_r    <= 1'b0;
         ld_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         ready_r    <= (state_nxt_s == RESP);
         ld_ready_r <= (state_nxt_s == LOAD);
         if (rd_en_s) begin
            rdata_r <= mem_r[rd_addr_s];
         end
      end
   end

`ifdef MEM_WAIT_EN
   // Wait counter and captured access request
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         cnt_r   <= 4'd0;
         rnw_r   <= 1'b1;
         addr_r  <= '0;
         wdata_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
         if (capture_s) begin
            rnw_r   <= R_NW;
            addr_r  <= addr;
            wdata_r <= wdata;
         end
      end
   end
`endif

   // Memory array; contents survive reset, writes blocked while reset is held
   always_ff @(posedge clock) begin
      if (mem_we_s && n_reset) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign rdata    = rdata_r;
   assign ready    = ready_r;
   assign ld_ready = ld_ready_r;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_responder;
   localparam int WORD_W      = 10;
   localparam int ADDR_W      = 7;
   localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_EN
   localparam int LAT = WAIT_CYCLES + 1;
`else
   localparam int LAT = 1;
`endif

   logic              clock = 1'b0;
   logic              n_reset = 1'b0;
   logic              CS = 1'b0;
   logic              R_NW = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [WORD_W-1:0] wdata = '0;
   logic [WORD_W-1:0] rdata;
   logic              ready;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [WORD_W-1:0] ld_data = '0;
   logic              ld_ready;

   int n_pass  = 0;
   int n_total = 0;

   mem_responder #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clock(clock), .n_reset(n_reset), .CS(CS), .R_NW(R_NW), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_ready(ld_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Transaction model: each access takes LAT cycles to its one-cycle response
   logic [WORD_W-1:0] m_mem [2**ADDR_W];
   logic [WORD_W-1:0] m_rdata = '0;
   logic              m_ready = 1'b0;
   logic              m_ld_ready = 1'b0;
   int                m_wait_left = 0;
   logic              m_rnw;
   logic [ADDR_W-1:0] m_addr;
   logic [WORD_W-1:0] m_wdata;

   task automatic model_access;
      if (m_rnw) m_rdata = m_mem[m_addr];
      else m_mem[m_addr] = m_wdata;
      m_ready = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clock or negedge n_reset);
         if (!n_reset) begin
            m_rdata = '0; m_ready = 1'b0; m_ld_ready = 1'b0; m_wait_left = 0;
         end else if (m_ready || m_ld_ready) begin
            m_ready = 1'b0; m_ld_ready = 1'b0;
         end else if (m_wait_left > 0) begin
            if (!CS) m_wait_left = 0;
            else begin
               m_wait_left--;
               if (m_wait_left == 0) model_access();
            end
         end else if (CS) begin
            m_rnw = R_NW; m_addr = addr; m_wdata = wdata;
            m_wait_left = LAT - 1;
            if (m_wait_left == 0) model_access();
         end else if (ld_valid) begin
            m_mem[ld_addr] = ld_data;
            m_ld_ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         check("ready", 32'(ready), 32'(m_ready));
         check("ld_ready", 32'(ld_ready), 32'(m_ld_ready));
         check("rdata", 32'(rdata), 32'(m_rdata));
         check("exclusive", 32'(ready & ld_ready), 32'd0);
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Issue one processor access, holding CS until ready or the cycle budget runs out
   task automatic access(input logic rnw, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d,
                         output int lat, output logic [WORD_W-1:0] rd, output logic ldr);
      R_NW = rnw; addr = a; wdata = d; CS = 1'b1;
      lat = 0; rd = '0; ldr = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick;
         if (ready) begin
            lat = n; rd = rdata; ldr = ld_ready;
            break;
         end
      end
      CS = 1'b0;
      tick;
   endtask

   int                lat;
   logic [WORD_W-1:0] rd;
   logic              ldr;
   logic [WORD_W-1:0] exp7;

   initial begin
      exp7 = (LAT > 1) ? 10'h077 : 10'h3FF;
      repeat (3) tick;
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      n_reset = 1'b1;
      tick;

      // loader write then read back
      ld_valid = 1'b1; ld_addr = 7'd5; ld_data = 10'h155;
      tick;
      check("ld_pulse", 32'(ld_ready), 32'd1);
      ld_valid = 1'b0;
      tick;
      check("ld_pulse_end", 32'(ld_ready), 32'd0);
      access(1'b1, 7'd5, 10'h000, lat, rd, ldr);
      check("lat_rd5", 32'(lat), 32'(LAT));
      check("rd5", 32'(rd), 32'h155);

      // write leaves rdata alone, then read it back
      access(1'b0, 7'd3, 10'h2AA, lat, rd, ldr);
      check("lat_wr3", 32'(lat), 32'(LAT));
      check("wr3_rdata_hold", 32'(rd), 32'h155);
      access(1'b1, 7'd3, 10'h000, lat, rd, ldr);
      check("rd3", 32'(rd), 32'h2AA);

      // CS beats a simultaneous loader request
      ld_valid = 1'b1; ld_addr = 7'd3; ld_data = 10'h001;
      access(1'b1, 7'd5, 10'h000, lat, rd, ldr);
      check("arb_ld_ready_low", 32'(ldr), 32'd0);
      check("arb_rd5", 32'(rd), 32'h155);
      tick;
      check("arb_ld_after", 32'(ld_ready), 32'd1);
      ld_valid = 1'b0;
      tick;
      access(1'b1, 7'd3, 10'h000, lat, rd, ldr);
      check("arb_rd3", 32'(rd), 32'h001);

      // loader request during LOAD is ignored
      ld_valid = 1'b1; ld_addr = 7'd9; ld_data = 10'h03C;
      tick;
      ld_data = 10'h111;
      tick;
      ld_valid = 1'b0;
      check("ld_ignored_pulse", 32'(ld_ready), 32'd0);
      tick;
      access(1'b1, 7'd9, 10'h000, lat, rd, ldr);
      check("rd9", 32'(rd), 32'h03C);

      // address and data extremes
      access(1'b0, 7'd0, 10'h3FF, lat, rd, ldr);
      access(1'b0, 7'd127, 10'h000, lat, rd, ldr);
      access(1'b1, 7'd0, 10'h000, lat, rd, ldr);
      check("rd0", 32'(rd), 32'h3FF);
      access(1'b1, 7'd127, 10'h000, lat, rd, ldr);
      check("rd127", 32'(rd), 32'h000);

`ifdef MEM_WAIT_EN
      // CS dropped in the first wait cycle aborts the write
      R_NW = 1'b0; addr = 7'd5; wdata = 10'h0F0; CS = 1'b1;
      tick;
      CS = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("abort_no_ready", 32'(ready), 32'd0);
      end
      access(1'b1, 7'd5, 10'h000, lat, rd, ldr);
      check("abort_rd5", 32'(rd), 32'h155);
`endif

      // reset during an in-flight write to address 7
      access(1'b0, 7'd7, 10'h077, lat, rd, ldr);
      R_NW = 1'b0; addr = 7'd7; wdata = 10'h3FF; CS = 1'b1;
      tick;
      n_reset = 1'b0;
      #1;
      check("rst_mid_ready", 32'(ready), 32'd0);
      check("rst_mid_rdata", 32'(rdata), 32'd0);
      CS = 1'b0;
      tick;
      tick;
      n_reset = 1'b1;
      tick;
      access(1'b1, 7'd7, 10'h000, lat, rd, ldr);
      check("rd7_after_rst", 32'(rd), 32'(exp7));

      repeat (2) tick;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WORD_W, default 10, data word width.
REQ-002 Parameter ADDR_W, default 7, address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states per access when MEM_WAIT_EN is defined; legal range 1..15.
REQ-004 clock  input  1  single system clock; all state changes on rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 CS  input  1  chip select from the processor sequencer.
REQ-007 R_NW  input  1  1 = read, 0 = write; sampled with CS.
REQ-008 addr  input  ADDR_W  access address (MAR).
REQ-009 wdata  input  WORD_W  write data (MDR).
REQ-010 rdata  output  WORD_W  registered read data.
REQ-011 ready  output  1  one-cycle pulse: access complete.
REQ-012 ld_valid  input  1  loader write request.
REQ-013 ld_addr  input  ADDR_W  loader address.
REQ-014 ld_data  input  WORD_W  loader data.
REQ-015 ld_ready  output  1  one-cycle pulse: loader write done.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP and LOAD.
REQ-017 In IDLE, on an edge with CS=1, the block SHALL capture addr, R_NW and wdata, and go to RESP (macro off) or WAIT (macro on).
REQ-018 With the macro off, a read SHALL load rdata from mem[addr] on the CS edge; a write SHALL update mem[addr] on the same edge; rdata SHALL be valid and ready=1 in the next cycle.
REQ-019 RESP SHALL last exactly one cycle with ready=1 and then return to IDLE; CS sampled in RESP SHALL be ignored.
REQ-020 A write SHALL leave rdata unchanged; rdata SHALL hold its value until the next completed read.
REQ-021 In IDLE, with CS=0 and ld_valid=1, the block SHALL write mem[ld_addr] with ld_data and enter LOAD; LOAD SHALL last one cycle with ld_ready=1 and then return to IDLE.
REQ-022 If CS=1 and ld_valid=1 together in IDLE, CS SHALL win; the loader SHALL wait, with ld_ready=0.
REQ-023 ld_valid outside IDLE SHALL be ignored; no memory change and ld_ready=0.
REQ-024 ready and ld_ready SHALL never both be 1.
REQ-025 Address arithmetic SHALL be unsigned; all ADDR_W values are valid and there is no out-of-range case.

Reset
REQ-026 While n_reset=0, the block SHALL have state=IDLE, rdata=0, ready=0, ld_ready=0 and the wait counter at 0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted in WAIT SHALL abandon the access; a pending write SHALL NOT be performed.

Configuration
REQ-029 Macro MEM_WAIT_EN: when defined, IDLE goes to WAIT, which SHALL count WAIT_CYCLES cycles with ready=0; the read or write SHALL occur on the final WAIT edge and be followed by RESP, giving ready WAIT_CYCLES+1 cycles after the CS edge.
REQ-030 With MEM_WAIT_EN defined, CS must stay high through WAIT; if CS=0 in any WAIT cycle, the access SHALL abort to IDLE with no write, rdata unchanged and no ready pulse.
REQ-031 With MEM_WAIT_EN undefined, no WAIT state or counter logic SHALL be present, and the latency SHALL be fixed at one cycle.

Verification
REQ-032 Loader writes 10'h155 to address 5; then CS=1, R_NW=1, addr=5 for one cycle -> ld_ready pulse after the load; next cycle ready=1 and rdata=10'h155.
REQ-033 CS=1, R_NW=0, addr=3, wdata=10'h2AA, then a read of address 3 -> rdata=10'h2AA; rdata is unchanged during the write's ready cycle.
REQ-034 CS=1 and ld_valid=1 (ld_addr=3, ld_data=10'h001) in the same IDLE cycle -> processor access completes first and ld_ready=0; the loader write completes in the cycle after RESP.
REQ-035 MEM_WAIT_EN defined, WAIT_CYCLES=2, read of address 5 with CS held -> ready=1 exactly 3 cycles after the CS edge, rdata=10'h155.
REQ-036 MEM_WAIT_EN defined, write 10'h0F0 to address 5, CS dropped in the first WAIT cycle -> no ready pulse; a later read of address 5 returns 10'h155.
REQ-037 n_reset pulsed low in WAIT during a write to address 7 -> outputs zero immediately; address 7 keeps its old value.
